// File: rtl/serial_word_deser.sv
// serial_word_deser: MSB-first serial-to-parallel word assembler with frame sync,
// a 2-entry output FIFO and sticky overflow / framing-error flags.
module serial_word_deser #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             CK,
  input  logic             RESET,
  input  logic             SD,
  input  logic             SE,
  input  logic             FS,
  output logic [WIDTH-1:0] Q,
  output logic             Q_VALID,
  input  logic             Q_READY,
  output logic             OVF,
  output logic             ERR
);

  localparam int unsigned  CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    HUNT = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] w_sr_nxt;
  logic [WIDTH-1:0] w_shift;
  logic [WIDTH-1:0] w_start;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_push;
  logic             w_err_set;

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_q2;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_q2_nxt;
  logic [1:0]       r_occ;
  logic [1:0]       w_occ_nxt;
  logic             r_q_valid;
  logic             r_ovf;
  logic             r_err;
  logic             w_ovf_set;
  logic             w_pop;

  assign w_shift = {r_sr[WIDTH-2:0], SD};
  assign w_start = {{(WIDTH-1){1'b0}}, SD};
  assign w_pop   = r_q_valid & Q_READY;

  // Receive FSM state register
  always_ff @(negedge CK) begin
    if (RESET) begin
      r_state <= HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Receive next-state, shift register and bit counter update
  always_comb begin
    w_state_nxt = r_state;
    w_sr_nxt    = r_sr;
    w_cnt_nxt   = r_cnt;
    w_push      = 1'b0;
    w_err_set   = 1'b0;
    if (SE) begin
      case (r_state)
        HUNT: begin
          if (FS) begin
            w_sr_nxt    = w_start;
            w_cnt_nxt   = CW'(1);
            w_state_nxt = RECV;
          end
        end
        RECV: begin
          if (FS) begin
            // FS with no bits pending is a clean word start; otherwise resync.
            w_sr_nxt  = w_start;
            w_cnt_nxt = CW'(1);
            w_err_set = (r_cnt != '0);
          end else if (r_cnt == LAST) begin
            w_sr_nxt  = w_shift;
            w_cnt_nxt = '0;
            w_push    = 1'b1;
          end else begin
            w_sr_nxt  = w_shift;
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        default: w_state_nxt = HUNT;
      endcase
    end
  end

  // Output FIFO: r_q is the head (drives Q directly), r_q2 the second entry
  always_comb begin
    w_q_nxt   = r_q;
    w_q2_nxt  = r_q2;
    w_occ_nxt = r_occ;
    w_ovf_set = 1'b0;
    case (r_occ)
      2'd0: begin
        if (w_push) begin
          w_q_nxt   = w_shift;
          w_occ_nxt = 2'd1;
        end
      end
      2'd1: begin
        case ({w_push, w_pop})
          2'b11: w_q_nxt = w_shift;
          2'b01: begin
            w_q_nxt   = '0;
            w_occ_nxt = 2'd0;
          end
          2'b10: begin
            w_q2_nxt  = w_shift;
            w_occ_nxt = 2'd2;
          end
          default: ;
        endcase
      end
      default: begin
        case ({w_push, w_pop})
          2'b11: begin
            w_q_nxt  = r_q2;
            w_q2_nxt = w_shift;
          end
          2'b01: begin
            w_q_nxt   = r_q2;
            w_q2_nxt  = '0;
            w_occ_nxt = 2'd1;
          end
          2'b10: w_ovf_set = 1'b1;
          default: ;
        endcase
      end
    endcase
  end

  // Datapath and flag registers
  always_ff @(negedge CK) begin
    if (RESET) begin
      r_sr      <= '0;
      r_cnt     <= '0;
      r_q       <= '0;
      r_q2      <= '0;
      r_occ     <= 2'd0;
      r_q_valid <= 1'b0;
      r_ovf     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_sr      <= w_sr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_q       <= w_q_nxt;
      r_q2      <= w_q2_nxt;
      r_occ     <= w_occ_nxt;
      r_q_valid <= (w_occ_nxt != 2'd0);
      r_ovf     <= r_ovf | w_ovf_set;
      r_err     <= r_err | w_err_set;
    end
  end

  assign Q       = r_q;
  assign Q_VALID = r_q_valid;
  assign OVF     = r_ovf;
  assign ERR     = r_err;

endmodule

// File: tb/tb_serial_word_deser.sv
// Self-checking bench for serial_word_deser (WIDTH=16): scoreboard of expected
// words, a table of back-to-back word vectors and hand-written corner sequences.
module tb_serial_word_deser;

  localparam int unsigned W = 16;

  logic         CK      = 1'b0;
  logic         RESET   = 1'b1;
  logic         SD      = 1'b0;
  logic         SE      = 1'b0;
  logic         FS      = 1'b0;
  logic         Q_READY = 1'b0;
  logic [W-1:0] Q;
  logic         Q_VALID;
  logic         OVF;
  logic         ERR;

  int           n_checks = 0;
  int           n_errors = 0;
  int           n_pops   = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [W-1:0] word;
    logic         fs;
    int           gap;
    logic         exp_err;
  } vec_t;

  vec_t vecs[6];

  always #5 CK = ~CK;

  serial_word_deser #(.WIDTH(W)) dut (
    .CK(CK), .RESET(RESET), .SD(SD), .SE(SE), .FS(FS),
    .Q(Q), .Q_VALID(Q_VALID), .Q_READY(Q_READY), .OVF(OVF), .ERR(ERR)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drive one edge's inputs; the consumer-side scoreboard compares any accepted word.
  task automatic cyc(input logic se, input logic fs, input logic sd, input logic rdy);
    SE = se; FS = fs; SD = sd; Q_READY = rdy;
    #1;
    if (Q_VALID === 1'b1 && Q_READY) begin
      n_pops++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_word actual=%0h required=none", Q);
      end else begin
        check("word", 32'(Q), 32'(exp_q.pop_front()));
      end
    end else if (Q_VALID === 1'b0) begin
      check("q_zero_when_invalid", 32'(Q), 32'h0);
    end
    @(negedge CK);
    #1;
  endtask

  task automatic send_bits(input logic [W-1:0] word, input int nbits, input logic fs,
                           input int gap, input logic rdy);
    for (int i = 0; i < nbits; i++) begin
      cyc(1'b1, fs && (i == 0), word[W-1-i], rdy);
      for (int g = 0; g < gap; g++) cyc(1'b0, 1'b1, 1'($urandom), rdy);
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    RESET = 1'b0;
    exp_q.delete();
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || Q_VALID !== 1'b0) && k < 64) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      k++;
    end
    check("drain_queue_empty", 32'(exp_q.size()), 32'h0);
    check("drain_valid_low", 32'(Q_VALID), 32'h0);
  endtask

  initial begin
    int p0;

    vecs[0] = '{word: 16'hFFFF, fs: 1'b1, gap: 0, exp_err: 1'b0};
    vecs[1] = '{word: 16'h0000, fs: 1'b0, gap: 2, exp_err: 1'b0};
    vecs[2] = '{word: 16'h8000, fs: 1'b1, gap: 0, exp_err: 1'b0};
    vecs[3] = '{word: 16'h0001, fs: 1'b0, gap: 1, exp_err: 1'b0};
    vecs[4] = '{word: 16'h6DB6, fs: 1'b1, gap: 3, exp_err: 1'b0};
    vecs[5] = '{word: 16'hC3A5, fs: 1'b0, gap: 0, exp_err: 1'b0};

    // Reset state
    do_reset();
    check("rst_q", 32'(Q), 32'h0);
    check("rst_valid", 32'(Q_VALID), 32'h0);
    check("rst_ovf", 32'(OVF), 32'h0);
    check("rst_err", 32'(ERR), 32'h0);

    // Single word, zero latency, valid for exactly one cycle
    exp_q.push_back(16'hA5C3);
    send_bits(16'hA5C3, 16, 1'b1, 0, 1'b1);
    check("t1_valid_after_last", 32'(Q_VALID), 32'h1);
    check("t1_q_after_last", 32'(Q), 32'hA5C3);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("t1_valid_one_cycle", 32'(Q_VALID), 32'h0);
    check("t1_err", 32'(ERR), 32'h0);
    check("t1_ovf", 32'(OVF), 32'h0);

    // Bits before FS are discarded in HUNT
    do_reset();
    p0 = n_pops;
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b1, 1'b1);
    check("t2_no_word_before_fs", 32'(Q_VALID), 32'h0);
    exp_q.push_back(16'h1234);
    send_bits(16'h1234, 16, 1'b1, 0, 1'b1);
    drain();
    check("t2_word_count", 32'(n_pops - p0), 32'd1);
    check("t2_err", 32'(ERR), 32'h0);

    // SE gaps (with FS toggling on idle edges) and back-to-back words without FS
    p0 = n_pops;
    exp_q.push_back(16'h8001);
    exp_q.push_back(16'h7FFE);
    send_bits(16'h8001, 16, 1'b1, 1, 1'b1);
    send_bits(16'h7FFE, 16, 1'b0, 1, 1'b1);
    drain();
    check("t3_word_count", 32'(n_pops - p0), 32'd2);
    check("t3_err", 32'(ERR), 32'h0);

    // Overflow: third word dropped while consumer stalls
    do_reset();
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0002);
    send_bits(16'h0001, 16, 1'b1, 0, 1'b0);
    send_bits(16'h0002, 16, 1'b0, 0, 1'b0);
    check("t4_ovf_before_third", 32'(OVF), 32'h0);
    send_bits(16'h0003, 16, 1'b0, 0, 1'b0);
    check("t4_ovf", 32'(OVF), 32'h1);
    check("t4_q_head", 32'(Q), 32'h0001);
    check("t4_valid", 32'(Q_VALID), 32'h1);
    drain();
    check("t4_ovf_sticky", 32'(OVF), 32'h1);

    // FS mid-word: partial word dropped, ERR set
    do_reset();
    p0 = n_pops;
    send_bits(16'h5555, 7, 1'b1, 0, 1'b1);
    check("t5_err_before", 32'(ERR), 32'h0);
    exp_q.push_back(16'hBEEF);
    send_bits(16'hBEEF, 16, 1'b1, 0, 1'b1);
    check("t5_err", 32'(ERR), 32'h1);
    drain();
    check("t5_word_count", 32'(n_pops - p0), 32'd1);
    check("t5_err_sticky", 32'(ERR), 32'h1);

    // Reset mid-word with a word buffered; reset beats SE/FS/Q_READY
    do_reset();
    exp_q.push_back(16'h1111);
    send_bits(16'h1111, 16, 1'b1, 0, 1'b0);
    send_bits(16'h2222, 10, 1'b0, 0, 1'b0);
    check("t6_buffered", 32'(Q_VALID), 32'h1);
    RESET = 1'b1;
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    RESET = 1'b0;
    exp_q.delete();
    check("t6_valid", 32'(Q_VALID), 32'h0);
    check("t6_q", 32'(Q), 32'h0);
    check("t6_ovf", 32'(OVF), 32'h0);
    check("t6_err", 32'(ERR), 32'h0);
    p0 = n_pops;
    send_bits(16'h3333, 16, 1'b0, 0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("t6_nothing_without_fs", 32'(n_pops - p0), 32'd0);
    exp_q.push_back(16'h4444);
    send_bits(16'h4444, 16, 1'b1, 0, 1'b1);
    drain();

    // Simultaneous push and pop on a full FIFO keeps order and raises no OVF
    do_reset();
    exp_q.push_back(16'h0F0F);
    exp_q.push_back(16'hF0F0);
    exp_q.push_back(16'h1357);
    send_bits(16'h0F0F, 16, 1'b1, 0, 1'b0);
    send_bits(16'hF0F0, 16, 1'b0, 0, 1'b0);
    send_bits(16'h1357, 15, 1'b0, 0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    check("t7_ovf", 32'(OVF), 32'h0);
    check("t7_head_after_swap", 32'(Q), 32'hF0F0);
    drain();

    // Table of back-to-back words with varied FS and SE gaps
    do_reset();
    p0 = n_pops;
    foreach (vecs[i]) begin
      exp_q.push_back(vecs[i].word);
      send_bits(vecs[i].word, 16, vecs[i].fs, vecs[i].gap, 1'b1);
      check("tbl_err", 32'(ERR), 32'(vecs[i].exp_err));
    end
    drain();
    check("tbl_word_count", 32'(n_pops - p0), 32'd6);
    check("tbl_ovf", 32'(OVF), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
